// File: rtl/varredura_display_pkg.sv
// ============================================================================
// Module : varredura_display_pkg
// Brief  : Shared display constants: blank/anode-off codes and hex segment map.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package varredura_display_pkg;

    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [3:0] c_AN_OFF    = 4'hF;

    // Active-low segment patterns for codes 0..F, bit0=a .. bit6=g.
    localparam logic [6:0] c_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/varredura_display_decodificador_7seg.sv
// ============================================================================
// Module : decodificador_7seg
// Brief  : Combinational 4-bit code to active-low 7-segment pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decodificador_7seg
    import varredura_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = c_SEG_TABLE[code_i];

endmodule

`default_nettype wire

// File: rtl/varredura_display.sv
// ============================================================================
// Module : varredura_display
// Brief  : 4-digit multiplexed common-anode display driver with tear-free
//          frame-synchronous digit snapshots.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module varredura_display
    import varredura_display_pkg::*;
#(
    parameter int DIV_COUNT = 50000,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       upd_i,
    input  logic [3:0] dig0_i,
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig2_i,
    input  logic [3:0] dig3_i,
    output logic [3:0] an_n_o,
    output logic [6:0] seg_n_o,
    output logic       frame_o,
    output logic       pend_o
);

    localparam logic [DIV_WIDTH-1:0] c_DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] r_div;
    logic [1:0]           r_idx;
    logic                 r_on;
    logic                 r_pend;
    logic [3:0][3:0]      r_snap;
    logic                 r_frame;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    logic                 w_tick;
    logic                 w_frame_end;
    logic                 w_capture;
    logic                 w_lit;
    logic [6:0]           w_seg;

    assign w_tick      = (r_div == c_DIV_LAST);
    assign w_frame_end = w_tick && r_on && (r_idx == 2'd3);
    // The very first tick primes the snapshots so the display never shows zeros.
    assign w_capture   = (w_tick && !r_on) || (w_frame_end && (r_pend || upd_i));
    assign w_lit       = r_on && en_i;

    decodificador_7seg u_decod (
        .code_i  (r_snap[r_idx]),
        .seg_n_o (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= 2'd0;
            r_on    <= 1'b0;
            r_pend  <= 1'b0;
            r_snap  <= '0;
            r_frame <= 1'b0;
            r_an    <= c_AN_OFF;
            r_seg   <= c_SEG_BLANK;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;

            if (w_tick) begin
                r_on <= 1'b1;
                if (r_on) begin
                    r_idx <= r_idx + 2'd1;
                end
            end

            // A request landing on the capturing tick is satisfied immediately.
            if (w_capture) begin
                r_snap <= {dig3_i, dig2_i, dig1_i, dig0_i};
                r_pend <= 1'b0;
            end else if (upd_i) begin
                r_pend <= 1'b1;
            end

            r_frame <= w_frame_end;
            r_an    <= w_lit ? ~(4'b0001 << r_idx) : c_AN_OFF;
            r_seg   <= w_lit ? w_seg : c_SEG_BLANK;
        end
    end

    assign an_n_o  = r_an;
    assign seg_n_o = r_seg;
    assign frame_o = r_frame;
    assign pend_o  = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_varredura_display.sv
// ============================================================================
// Module : tb_varredura_display
// Brief  : Directed self-checking bench for varredura_display (DIV_COUNT=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_varredura_display;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i  = 1'b1;
    logic       upd_i = 1'b0;
    logic [3:0] dig0_i = 4'h1;
    logic [3:0] dig1_i = 4'h2;
    logic [3:0] dig2_i = 4'h3;
    logic [3:0] dig3_i = 4'h4;
    logic [3:0] an_n_o;
    logic [6:0] seg_n_o;
    logic       frame_o;
    logic       pend_o;

    int vecs = 0;
    int errs = 0;
    int t    = 0;   // rising edges since the last reset release

    varredura_display #(
        .DIV_COUNT (4),
        .DIV_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_i),
        .upd_i   (upd_i),
        .dig0_i  (dig0_i),
        .dig1_i  (dig1_i),
        .dig2_i  (dig2_i),
        .dig3_i  (dig3_i),
        .an_n_o  (an_n_o),
        .seg_n_o (seg_n_o),
        .frame_o (frame_o),
        .pend_o  (pend_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after rising edge e (counted from reset release).
    task automatic go_to(input int e);
        while (t < e) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (an_n_o !== 4'hF || seg_n_o !== 7'h7F) begin
            errs++;
            $display("FAIL reset_out: an=%b seg=%h expected an=1111 seg=7f", an_n_o, seg_n_o);
        end
        vecs++;
        if (frame_o !== 1'b0 || pend_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: frame=%b pend=%b expected 0 0", frame_o, pend_o);
        end
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_first_tick();
        for (int e = 1; e <= 4; e++) begin
            go_to(e);
            vecs++;
            if (an_n_o !== 4'hF || seg_n_o !== 7'h7F) begin
                errs++;
                $display("FAIL dark_edge%0d: an=%b seg=%h expected 1111/7f", e, an_n_o, seg_n_o);
            end
        end
        go_to(5);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h79) begin
            errs++;
            $display("FAIL scan_d0: an=%b seg=%h expected 1110/79", an_n_o, seg_n_o);
        end
        go_to(9);
        vecs++;
        if (an_n_o !== 4'b1101 || seg_n_o !== 7'h24) begin
            errs++;
            $display("FAIL scan_d1: an=%b seg=%h expected 1101/24", an_n_o, seg_n_o);
        end
        go_to(13);
        vecs++;
        if (an_n_o !== 4'b1011 || seg_n_o !== 7'h30) begin
            errs++;
            $display("FAIL scan_d2: an=%b seg=%h expected 1011/30", an_n_o, seg_n_o);
        end
        go_to(17);
        vecs++;
        if (an_n_o !== 4'b0111 || seg_n_o !== 7'h19) begin
            errs++;
            $display("FAIL scan_d3: an=%b seg=%h expected 0111/19", an_n_o, seg_n_o);
        end
    endtask

    task automatic test_frame();
        go_to(19);
        vecs++;
        if (frame_o !== 1'b0) begin
            errs++;
            $display("FAIL frame_pre: frame=%b expected 0", frame_o);
        end
        go_to(20);
        vecs++;
        if (frame_o !== 1'b1) begin
            errs++;
            $display("FAIL frame_pulse1: frame=%b expected 1", frame_o);
        end
        go_to(21);
        vecs++;
        if (frame_o !== 1'b0 || an_n_o !== 4'b1110 || seg_n_o !== 7'h79) begin
            errs++;
            $display("FAIL frame_wrap: frame=%b an=%b seg=%h expected 0 1110/79", frame_o, an_n_o, seg_n_o);
        end
        go_to(35);
        vecs++;
        if (frame_o !== 1'b0) begin
            errs++;
            $display("FAIL frame_gap: frame=%b expected 0", frame_o);
        end
        go_to(36);
        vecs++;
        if (frame_o !== 1'b1) begin
            errs++;
            $display("FAIL frame_pulse2: frame=%b expected 1", frame_o);
        end
    endtask

    task automatic test_tear_free();
        go_to(38);
        dig0_i = 4'h8;
        go_to(53);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h79) begin
            errs++;
            $display("FAIL hold_f1: an=%b seg=%h expected 1110/79", an_n_o, seg_n_o);
        end
        go_to(69);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h79) begin
            errs++;
            $display("FAIL hold_f2: an=%b seg=%h expected 1110/79", an_n_o, seg_n_o);
        end
        go_to(70);
        upd_i = 1'b1;
        go_to(71);
        upd_i = 1'b0;
        vecs++;
        if (pend_o !== 1'b1) begin
            errs++;
            $display("FAIL pend_set: pend=%b expected 1", pend_o);
        end
        go_to(83);
        vecs++;
        if (pend_o !== 1'b1) begin
            errs++;
            $display("FAIL pend_hold: pend=%b expected 1", pend_o);
        end
        go_to(84);
        vecs++;
        if (pend_o !== 1'b0) begin
            errs++;
            $display("FAIL pend_clear: pend=%b expected 0", pend_o);
        end
        go_to(85);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h00) begin
            errs++;
            $display("FAIL upd_show: an=%b seg=%h expected 1110/00", an_n_o, seg_n_o);
        end
    endtask

    task automatic test_simultaneous();
        go_to(99);
        dig1_i = 4'hA;
        upd_i  = 1'b1;
        go_to(100);
        upd_i = 1'b0;
        vecs++;
        if (pend_o !== 1'b0 || frame_o !== 1'b1) begin
            errs++;
            $display("FAIL simul_pend: pend=%b frame=%b expected 0 1", pend_o, frame_o);
        end
        go_to(101);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h00) begin
            errs++;
            $display("FAIL simul_d0: an=%b seg=%h expected 1110/00", an_n_o, seg_n_o);
        end
        go_to(105);
        vecs++;
        if (an_n_o !== 4'b1101 || seg_n_o !== 7'h08) begin
            errs++;
            $display("FAIL simul_d1: an=%b seg=%h expected 1101/08", an_n_o, seg_n_o);
        end
    endtask

    task automatic test_blank();
        go_to(106);
        en_i = 1'b0;
        go_to(107);
        vecs++;
        if (an_n_o !== 4'hF || seg_n_o !== 7'h7F) begin
            errs++;
            $display("FAIL blank_start: an=%b seg=%h expected 1111/7f", an_n_o, seg_n_o);
        end
        go_to(108);
        dig2_i = 4'h5;
        upd_i  = 1'b1;
        go_to(109);
        upd_i = 1'b0;
        vecs++;
        if (pend_o !== 1'b1) begin
            errs++;
            $display("FAIL blank_pend: pend=%b expected 1", pend_o);
        end
        for (int e = 110; e <= 126; e++) begin
            go_to(e);
            vecs++;
            if (an_n_o !== 4'hF || seg_n_o !== 7'h7F) begin
                errs++;
                $display("FAIL blank_edge%0d: an=%b seg=%h expected 1111/7f", e, an_n_o, seg_n_o);
            end
            if (e == 115) begin
                vecs++;
                if (frame_o !== 1'b0) begin
                    errs++;
                    $display("FAIL blank_frame_pre: frame=%b expected 0", frame_o);
                end
            end
            if (e == 116) begin
                vecs++;
                if (frame_o !== 1'b1 || pend_o !== 1'b0) begin
                    errs++;
                    $display("FAIL blank_frame: frame=%b pend=%b expected 1 0", frame_o, pend_o);
                end
            end
        end
        en_i = 1'b1;
        go_to(127);
        vecs++;
        if (an_n_o !== 4'b1011 || seg_n_o !== 7'h12) begin
            errs++;
            $display("FAIL blank_resume: an=%b seg=%h expected 1011/12", an_n_o, seg_n_o);
        end
    endtask

    task automatic test_reset_mid();
        go_to(140);
        upd_i = 1'b1;
        go_to(141);
        upd_i = 1'b0;
        go_to(142);
        vecs++;
        if (pend_o !== 1'b1 || an_n_o !== 4'b1011 || seg_n_o !== 7'h12) begin
            errs++;
            $display("FAIL mid_pre: pend=%b an=%b seg=%h expected 1 1011/12", pend_o, an_n_o, seg_n_o);
        end
        rst_n = 1'b0;
        #2;
        vecs++;
        if (an_n_o !== 4'hF || seg_n_o !== 7'h7F || frame_o !== 1'b0 || pend_o !== 1'b0) begin
            errs++;
            $display("FAIL mid_async: an=%b seg=%h frame=%b pend=%b expected 1111/7f 0 0",
                     an_n_o, seg_n_o, frame_o, pend_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        go_to(4);
        vecs++;
        if (an_n_o !== 4'hF || seg_n_o !== 7'h7F) begin
            errs++;
            $display("FAIL rearm_dark: an=%b seg=%h expected 1111/7f", an_n_o, seg_n_o);
        end
        go_to(5);
        vecs++;
        if (an_n_o !== 4'b1110 || seg_n_o !== 7'h00) begin
            errs++;
            $display("FAIL rearm_d0: an=%b seg=%h expected 1110/00", an_n_o, seg_n_o);
        end
        go_to(9);
        vecs++;
        if (an_n_o !== 4'b1101 || seg_n_o !== 7'h08) begin
            errs++;
            $display("FAIL rearm_d1: an=%b seg=%h expected 1101/08", an_n_o, seg_n_o);
        end
        go_to(13);
        vecs++;
        if (an_n_o !== 4'b1011 || seg_n_o !== 7'h12) begin
            errs++;
            $display("FAIL rearm_d2: an=%b seg=%h expected 1011/12", an_n_o, seg_n_o);
        end
        go_to(17);
        vecs++;
        if (an_n_o !== 4'b0111 || seg_n_o !== 7'h19) begin
            errs++;
            $display("FAIL rearm_d3: an=%b seg=%h expected 0111/19", an_n_o, seg_n_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_frame();
        test_tear_free();
        test_simultaneous();
        test_blank();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/varredura_display.md
Name: varredura_display

Overview:
- Downstream consumer of the status-to-digit stage. Takes four 4-bit digit codes (the status digit plus three neighbouring digit codes) and drives a 4-digit multiplexed common-anode 7-segment display.
- Contains a refresh divider, a digit scan counter, frame-synchronous snapshot registers (tear-free updates) and a hex-to-segment decoder.
- Sits between the digit-code generators and the board display pins.

Parameters:
- DIV_COUNT, 50000, clk cycles per digit slot (50 MHz gives 1 kHz per digit); must be >= 2.
- DIV_WIDTH, 16, width of the divider counter; must hold DIV_COUNT-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  display enable; 0 blanks the outputs, scanning continues
- upd_i  in  1  update request pulse; new digits are captured at the next frame end
- dig0_i  in  4  digit code for position 0 (rightmost)
- dig1_i  in  4  digit code for position 1
- dig2_i  in  4  digit code for position 2
- dig3_i  in  4  digit code for position 3 (leftmost)
- an_n_o  out  4  anode selects, active-low, one-hot when lit
- seg_n_o  out  7  segments, active-low; bit0=a … bit6=g
- frame_o  out  1  one-cycle pulse at frame end (snapshot instant)
- pend_o  out  1  an update request is pending

Behaviour:
- Reset (asynchronous, rst_n=0): divider=0, idx=0, on=0, pend=0, snapshots=0, an_n_o=4'hF, seg_n_o=7'h7F, frame_o=0.
- Divider counts 0..DIV_COUNT-1 and wraps. tick=1 when divider==DIV_COUNT-1.
- First tick after reset:
  - on goes 0→1; idx stays 0.
  - All four snapshots are loaded unconditionally from dig*_i.
  - pend clears; frame_o does not pulse.
- Later ticks: idx increments 0→1→2→3→0 (2-bit wrap).
- Frame end is a tick with on=1 and idx==3.
  - If pend=1 or upd_i=1 that cycle: load snapshots from dig*_i and clear pend.
  - frame_o=1 for exactly one cycle, registered, asserted the cycle after the frame-end tick.
- pend: set on upd_i=1 outside a capturing tick. If upd_i coincides with a capturing tick, the capture takes that cycle's inputs and pend ends 0.
- Outputs are registered with one cycle of latency from (on, idx, en_i, snapshot):
  - on=0 or en_i=0: an_n_o=4'hF, seg_n_o=7'h7F.
  - Otherwise: an_n_o = ~(1<<idx), seg_n_o = decode(snap[idx]).
- Decode table (seg_n_o hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- en_i low does not affect divider, idx, pend or snapshot capture.
- dig*_i changes between frame ends have no visible effect.
- rst_n asserted mid-frame: immediate return to reset values; the sequence restarts with the first-tick rule.

Decomposition:
- Shared include file holds:
  - segment constants SEG_BLANK=7'h7F and the 16 digit patterns;
  - AN_OFF=4'hF.
- Sub-module decodificador_7seg: purely combinational 4-bit code → 7-bit active-low segments. Instantiated once on the muxed snapshot.
- Divider, scan counter, pend/snapshot logic and output registers stay in varredura_display.

Test Plan (DIV_COUNT=4):
- Reset/first tick:
  - Release rst_n with dig3..0=4,3,2,1 → outputs stay 4'hF/7'h7F through cycle 4.
  - Next cycle: an_n_o=4'b1110, seg_n_o=79.
  - Then every 4 cycles: 1101/24, 1011/30, 0111/19.
- Wrap/frame:
  - After idx 3 → frame_o pulses once, one cycle after the tick.
  - Next digit shown is an_n_o=1110 again; frame_o period is 16 cycles.
- Tear-free update:
  - Change dig0_i to 8 mid-frame without upd_i → seg for digit 0 stays 79 indefinitely.
  - Pulse upd_i → pend_o=1 until the frame end, then digit 0 shows 00.
- Simultaneous:
  - upd_i coincident with the frame-end tick, dig1_i=A → pend_o stays 0.
  - Digit 1 shows 08 in the next frame.
- Blank:
  - en_i=0 for 20 cycles → an_n_o=F, seg_n_o=7F.
  - frame_o keeps its 16-cycle period; an upd_i during blank is captured.
  - On en_i=1, outputs resume on the current idx.
- Reset mid-operation:
  - Assert rst_n=0 while idx=2 and pend=1 → all outputs are at reset values asynchronously.
  - After release, the first-tick rule repeats.
